// File: rtl/loc_ckpt_pkg.sv
// Shared types and default geometry for the location checkpoint stack and its controllers.
package loc_ckpt_pkg;

  typedef enum logic {IDLE, DUMP} ckpt_state_t;

  localparam int LOC_W_DEF = 8;
  localparam int DEPTH_DEF = 4;

endpackage

// File: rtl/loc_ring_mem.sv
// DEPTH x LOC_W register ring: one synchronous write port, two combinational read ports.
// Contents are deliberately not reset; validity is tracked by the owner's count.
module loc_ring_mem #(
  parameter int LOC_W = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [LOC_W-1:0] wdata,
  input  logic [AW-1:0]    top_addr,
  output logic [LOC_W-1:0] top_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [LOC_W-1:0] rd_data
);

  logic [LOC_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign top_data = mem[top_addr];
  assign rd_data  = mem[rd_addr];

endmodule

// File: rtl/loc_checkpoint_stack.sv
// LIFO ring of the last DEPTH saved locations with push/pop/replace/clear and oldest-first replay.
// Commands take effect at the clock edge; replay advances one beat per valid/ready handshake.
module loc_checkpoint_stack
  import loc_ckpt_pkg::*;
#(
  parameter int LOC_W = LOC_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LOC_W-1:0] loc_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic             dump_i,
  input  logic             dump_ready_i,
  output logic [LOC_W-1:0] loc_top_o,
  output logic             top_valid_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_o,
  output logic [LOC_W-1:0] dump_data_o,
  output logic             dump_valid_o,
  output logic             dump_last_o,
  output logic             busy_o
);

  localparam int AW = $clog2(DEPTH);

  ckpt_state_t      state_q, state_d;
  logic [AW-1:0]    wr_ptr, rd_ptr, top_ptr, waddr;
  logic [CNT_W-1:0] count, remain;
  logic             overflow;
  logic             is_full, is_empty, in_idle, in_dump;
  logic             start_dump, cmd_en, hs;
  logic             do_clear, do_push, do_replace, do_pop, we;
  logic [LOC_W-1:0] top_data, rd_data;

  assign is_full  = (count == CNT_W'(DEPTH));
  assign is_empty = (count == '0);
  assign in_idle  = (state_q == IDLE);
  assign in_dump  = (state_q == DUMP);
  assign top_ptr  = wr_ptr - AW'(1);

  // A dump request wins over every stack command in the same cycle.
  assign start_dump = in_idle & dump_i & ~is_empty;
  assign cmd_en     = in_idle & ~start_dump;
  assign do_clear   = cmd_en & clear_i;
  assign do_replace = cmd_en & ~clear_i & push_i & pop_i & ~is_empty;
  assign do_push    = cmd_en & ~clear_i & push_i & ~do_replace;
  assign do_pop     = cmd_en & ~clear_i & pop_i & ~push_i & ~is_empty;
  assign we         = do_push | do_replace;
  assign waddr      = do_replace ? top_ptr : wr_ptr;
  assign hs         = in_dump & dump_ready_i;

  loc_ring_mem #(
    .LOC_W (LOC_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk      (clk),
    .we       (we),
    .waddr    (waddr),
    .wdata    (loc_i),
    .top_addr (top_ptr),
    .top_data (top_data),
    .rd_addr  (rd_ptr),
    .rd_data  (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (do_clear) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (do_push) begin
      wr_ptr <= wr_ptr + AW'(1);
      // When full the write lands on the oldest slot, so count saturates.
      if (is_full) overflow <= 1'b1;
      else         count    <= count + CNT_W'(1);
    end else if (do_pop) begin
      wr_ptr <= wr_ptr - AW'(1);
      count  <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      remain <= '0;
    end else if (start_dump) begin
      // A full ring yields rd_ptr == wr_ptr, which is exactly the oldest slot.
      rd_ptr <= wr_ptr - count[AW-1:0];
      remain <= count;
    end else if (hs) begin
      rd_ptr <= rd_ptr + AW'(1);
      remain <= remain - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_dump) state_d = DUMP;
      DUMP:    if (hs && remain == CNT_W'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign loc_top_o    = is_empty ? '0 : top_data;
  assign top_valid_o  = ~is_empty;
  assign count_o      = count;
  assign full_o       = is_full;
  assign empty_o      = is_empty;
  assign overflow_o   = overflow;
  assign dump_valid_o = in_dump;
  assign dump_data_o  = in_dump ? rd_data : '0;
  assign dump_last_o  = in_dump & (remain == CNT_W'(1));
  assign busy_o       = in_dump;

endmodule

// File: tb/tb_loc_checkpoint_stack.sv
// Directed vector bench for loc_checkpoint_stack (LOC_W=8, DEPTH=4).
module tb_loc_checkpoint_stack;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] loc_i = '0;
  logic       push_i = 1'b0, pop_i = 1'b0, clear_i = 1'b0, dump_i = 1'b0, dump_ready_i = 1'b0;
  logic [7:0] loc_top_o, dump_data_o;
  logic [2:0] count_o;
  logic       top_valid_o, full_o, empty_o, overflow_o, dump_valid_o, dump_last_o, busy_o;

  loc_checkpoint_stack #(.LOC_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .loc_i(loc_i), .push_i(push_i), .pop_i(pop_i),
    .clear_i(clear_i), .dump_i(dump_i), .dump_ready_i(dump_ready_i),
    .loc_top_o(loc_top_o), .top_valid_o(top_valid_o), .count_o(count_o),
    .full_o(full_o), .empty_o(empty_o), .overflow_o(overflow_o),
    .dump_data_o(dump_data_o), .dump_valid_o(dump_valid_o),
    .dump_last_o(dump_last_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] NOP = 5'b00000, PUSH = 5'b10000, POP = 5'b01000,
                         CLR = 5'b00100, DMP = 5'b00010, RDY = 5'b00001;
  // Reset/empty image: {top, count, full, empty, ovf, dv, dd, dl, busy}
  localparam logic [25:0] RST_IMG = {8'h00, 3'd0, 3'b010, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

  typedef struct {
    string       name;
    logic [4:0]  cmd;
    logic [7:0]  loc;
    logic [25:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   hs_cnt = 0;

  always @(posedge clk) if (dump_valid_o && dump_ready_i) hs_cnt <= hs_cnt + 1;

  task automatic add(input string name, input logic [4:0] cmd, input logic [7:0] loc,
                     input logic [7:0] top, input logic [2:0] cnt, input logic [2:0] flg,
                     input logic dv, input logic [7:0] dd, input logic dl);
    vec_t v;
    v.name = name; v.cmd = cmd; v.loc = loc;
    // top_valid is implied by a non-zero count; busy always equals dump_valid.
    v.exp  = {top, cnt, flg, (cnt != 3'd0), dv, dd, dl, dv};
    vecs.push_back(v);
  endtask

  function automatic logic [25:0] snap();
    return {loc_top_o, count_o, full_o, empty_o, overflow_o, top_valid_o,
            dump_valid_o, dump_data_o, dump_last_o, busy_o};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] cmd, input logic [7:0] loc);
    {push_i, pop_i, clear_i, dump_i, dump_ready_i} = cmd;
    loc_i = loc;
  endtask

  initial begin
    // 1: push three, pop past empty
    add("t1 push11", PUSH, 8'h11, 8'h11, 3'd1, 3'b000, 0, 8'h00, 0);
    add("t1 push22", PUSH, 8'h22, 8'h22, 3'd2, 3'b000, 0, 8'h00, 0);
    add("t1 push33", PUSH, 8'h33, 8'h33, 3'd3, 3'b000, 0, 8'h00, 0);
    add("t1 pop1",   POP,  8'h00, 8'h22, 3'd2, 3'b000, 0, 8'h00, 0);
    add("t1 pop2",   POP,  8'h00, 8'h11, 3'd1, 3'b000, 0, 8'h00, 0);
    add("t1 pop3",   POP,  8'h00, 8'h00, 3'd0, 3'b010, 0, 8'h00, 0);
    add("t1 popemp", POP,  8'h00, 8'h00, 3'd0, 3'b010, 0, 8'h00, 0);
    // 2: overflow then full-speed dump, then clear
    add("t2 push01", PUSH, 8'h01, 8'h01, 3'd1, 3'b000, 0, 8'h00, 0);
    add("t2 push02", PUSH, 8'h02, 8'h02, 3'd2, 3'b000, 0, 8'h00, 0);
    add("t2 push03", PUSH, 8'h03, 8'h03, 3'd3, 3'b000, 0, 8'h00, 0);
    add("t2 push04", PUSH, 8'h04, 8'h04, 3'd4, 3'b100, 0, 8'h00, 0);
    add("t2 push05", PUSH, 8'h05, 8'h05, 3'd4, 3'b101, 0, 8'h00, 0);
    add("t2 dump02", DMP | RDY, 8'h00, 8'h05, 3'd4, 3'b101, 1, 8'h02, 0);
    add("t2 beat03", RDY,  8'h00, 8'h05, 3'd4, 3'b101, 1, 8'h03, 0);
    add("t2 beat04", RDY,  8'h00, 8'h05, 3'd4, 3'b101, 1, 8'h04, 0);
    add("t2 beat05", RDY,  8'h00, 8'h05, 3'd4, 3'b101, 1, 8'h05, 1);
    add("t2 dmpend", RDY,  8'h00, 8'h05, 3'd4, 3'b101, 0, 8'h00, 0);
    add("t2 clear",  CLR,  8'h00, 8'h00, 3'd0, 3'b010, 0, 8'h00, 0);
    // 3: replace-top, then replace on empty behaves as push
    add("t3 pushA0", PUSH, 8'hA0, 8'hA0, 3'd1, 3'b000, 0, 8'h00, 0);
    add("t3 pushA1", PUSH, 8'hA1, 8'hA1, 3'd2, 3'b000, 0, 8'h00, 0);
    add("t3 replB7", PUSH | POP, 8'hB7, 8'hB7, 3'd2, 3'b000, 0, 8'h00, 0);
    add("t3 popA0",  POP,  8'h00, 8'hA0, 3'd1, 3'b000, 0, 8'h00, 0);
    add("t3 popemp", POP,  8'h00, 8'h00, 3'd0, 3'b010, 0, 8'h00, 0);
    add("t3 replemp", PUSH | POP, 8'hB7, 8'hB7, 3'd1, 3'b000, 0, 8'h00, 0);
    // 6: clear beats a same-cycle push and drops overflow
    add("t6 pushC1", PUSH, 8'hC1, 8'hC1, 3'd2, 3'b000, 0, 8'h00, 0);
    add("t6 pushC2", PUSH, 8'hC2, 8'hC2, 3'd3, 3'b000, 0, 8'h00, 0);
    add("t6 pushC3", PUSH, 8'hC3, 8'hC3, 3'd4, 3'b100, 0, 8'h00, 0);
    add("t6 pushC4", PUSH, 8'hC4, 8'hC4, 3'd4, 3'b101, 0, 8'h00, 0);
    add("t6 pop1",   POP,  8'h00, 8'hC3, 3'd3, 3'b001, 0, 8'h00, 0);
    add("t6 pop2",   POP,  8'h00, 8'hC2, 3'd2, 3'b001, 0, 8'h00, 0);
    add("t6 clrpush", CLR | PUSH, 8'hEE, 8'h00, 3'd0, 3'b010, 0, 8'h00, 0);
    add("dump empty", DMP | RDY, 8'h00, 8'h00, 3'd0, 3'b010, 0, 8'h00, 0);
    // 4: throttled dump with commands ignored while busy
    add("t4 push61", PUSH, 8'h61, 8'h61, 3'd1, 3'b000, 0, 8'h00, 0);
    add("t4 push62", PUSH, 8'h62, 8'h62, 3'd2, 3'b000, 0, 8'h00, 0);
    add("t4 push63", PUSH, 8'h63, 8'h63, 3'd3, 3'b000, 0, 8'h00, 0);
    add("t4 dump",   DMP,  8'h00, 8'h63, 3'd3, 3'b000, 1, 8'h61, 0);
    add("t4 hold61a", PUSH, 8'hFF, 8'h63, 3'd3, 3'b000, 1, 8'h61, 0);
    add("t4 hold61b", POP, 8'h00, 8'h63, 3'd3, 3'b000, 1, 8'h61, 0);
    add("t4 beat62", RDY,  8'h00, 8'h63, 3'd3, 3'b000, 1, 8'h62, 0);
    add("t4 hold62a", CLR, 8'h00, 8'h63, 3'd3, 3'b000, 1, 8'h62, 0);
    add("t4 hold62b", NOP, 8'h00, 8'h63, 3'd3, 3'b000, 1, 8'h62, 0);
    add("t4 beat63", RDY,  8'h00, 8'h63, 3'd3, 3'b000, 1, 8'h63, 1);
    add("t4 hold63a", PUSH | POP, 8'h99, 8'h63, 3'd3, 3'b000, 1, 8'h63, 1);
    add("t4 hold63b", DMP, 8'h00, 8'h63, 3'd3, 3'b000, 1, 8'h63, 1);
    add("t4 dmpend", RDY,  8'h00, 8'h63, 3'd3, 3'b000, 0, 8'h00, 0);

    #12;
    chk("reset state", {6'd0, snap()}, {6'd0, RST_IMG});
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      drive(vecs[i].cmd, vecs[i].loc);
      @(posedge clk); #1;
      chk(vecs[i].name, {6'd0, snap()}, {6'd0, vecs[i].exp});
    end
    drive(NOP, 8'h00);
    chk("handshakes t2+t4", hs_cnt, 7);

    // 5: asynchronous reset one beat into a dump
    drive(DMP | RDY, 8'h00);
    @(posedge clk); #1;
    chk("t5 beat61", {24'd0, dump_valid_o, dump_data_o}, {24'd0, 1'b1, 8'h61});
    drive(RDY, 8'h00);
    @(posedge clk); #1;
    chk("t5 beat62", {24'd0, dump_valid_o, dump_data_o}, {24'd0, 1'b1, 8'h62});
    drive(NOP, 8'h00);
    #2 rst = 1'b1;
    #1 chk("t5 async rst", {6'd0, snap()}, {6'd0, RST_IMG});
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(DMP | RDY, 8'h00);
      @(posedge clk); #1;
      chk($sformatf("t5 nodump%0d", k), {6'd0, snap()}, {6'd0, RST_IMG});
    end
    drive(NOP, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/loc_checkpoint_stack.md
Name: loc_checkpoint_stack

Overview:
- Parametrised successor to the single-entry location safe register.
- Keeps the last DEPTH saved locations as a LIFO checkpoint ring. Supports push (save), pop (roll back to the previous checkpoint), clear, and in-order replay of all held checkpoints over a valid/ready stream.
- Sits beside the RC4 key-search / Sobel address controllers.
- Lets a controller back off more than one step and lets a debug/readout path drain the history.

Parameters:
- LOC_W, 8, width of one stored location.
- DEPTH, 4, number of checkpoint entries. Power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- loc_i  in  LOC_W  location to save.
- push_i  in  1  save loc_i as the new top.
- pop_i  in  1  discard the top entry.
- clear_i  in  1  empty the stack and clear the overflow flag.
- dump_i  in  1  start a replay of all held entries.
- dump_ready_i  in  1  consumer accepts dump_data_o.
- loc_top_o  out  LOC_W  newest saved location.
- top_valid_o  out  1  stack non-empty.
- count_o  out  CNT_W  number of held entries, 0..DEPTH.
- full_o  out  1  count_o == DEPTH.
- empty_o  out  1  count_o == 0.
- overflow_o  out  1  sticky: a push overwrote the oldest entry.
- dump_data_o  out  LOC_W  replay data.
- dump_valid_o  out  1  replay data valid.
- dump_last_o  out  1  current replay beat is the newest entry.
- busy_o  out  1  replay in progress.

Behaviour:
- **Reset (async, rst=1):** wr_ptr=0, count=0, overflow=0, FSM=IDLE. All outputs 0 except empty_o=1. Storage array is not reset.
- **Storage model:** circular array mem[DEPTH]. wr_ptr is the next write slot; the top entry is mem[wr_ptr-1], with pointer arithmetic mod DEPTH (natural wrap at $clog2(DEPTH) bits).
- **Output timing:** loc_top_o is mem[wr_ptr-1] when count>0, else 0. It reflects state registered at the previous edge, so a push is visible one cycle later.
- **IDLE command priority:** clear > push/pop.
  - clear_i: count=0, overflow=0; pointers and mem unchanged.
  - push only, count<DEPTH: mem[wr_ptr]=loc_i, wr_ptr++, count++.
  - push only, count==DEPTH: same write and wr_ptr++. count stays DEPTH (oldest entry lost). overflow=1, sticky until clear or reset.
  - pop only, count>0: wr_ptr--, count--.
  - pop only, count==0: ignored, no state change.
  - push+pop, count>0: replace top. mem[wr_ptr-1]=loc_i; pointers, count and overflow unchanged.
  - push+pop, count==0: treated as push only.
- **FSM states:** IDLE, DUMP.
  - IDLE -> DUMP: dump_i=1 and count>0 (dump_i has priority over push/pop/clear in the same cycle; those are dropped). Load rd_ptr=wr_ptr-count (oldest entry) and remain=count.
  - IDLE, dump_i with count==0: stays in IDLE; no beats.
  - In DUMP:
    - dump_valid_o=1, dump_data_o=mem[rd_ptr], dump_last_o=(remain==1), busy_o=1.
    - On dump_valid_o & dump_ready_i: rd_ptr++, remain--. If remain==1 at that handshake -> IDLE.
    - dump_data_o must hold stable while dump_ready_i=0.
    - push/pop/clear/dump_i are ignored. Stack contents and count are unchanged by the replay.
  - Outside DUMP: dump_valid_o, dump_last_o and dump_data_o are 0.
- **Reset mid-replay:** immediately IDLE with all state as for reset. No further beats.
- **Flag definitions:** full_o and empty_o are purely decoded from count.

Decomposition:
- Package loc_ckpt_pkg holds:
  - typedef enum logic {IDLE, DUMP} ckpt_state_t;
  - default LOC_W / DEPTH localparams shared with the controllers.
- One natural sub-module: loc_ring_mem.
  - DEPTH x LOC_W register array, one synchronous write port, two combinational read ports (top and replay), no reset.
- Pointer, count, flag and FSM logic stay in loc_checkpoint_stack.

Test Plan (LOC_W=8, DEPTH=4):
1. Reset, then push 0x11, 0x22, 0x33 on consecutive cycles.
   - Top sequence (cycle after each push): 0x11, 0x22, 0x33; count_o=3.
   - Then pop x2 -> loc_top_o=0x11, count_o=1. Then pop x2 more -> empty_o=1, loc_top_o=0, second pop on empty ignored.
2. Push 0x01..0x05.
   - full_o=1 after the 4th push. overflow_o=1 after the 5th; count_o=4, loc_top_o=0x05.
   - Dump with dump_ready_i=1 -> beats 0x02, 0x03, 0x04, 0x05, dump_last_o only on 0x05.
   - clear_i -> overflow_o=0, empty_o=1.
3. With stack holding 0xA0, 0xA1, assert push_i+pop_i with loc_i=0xB7.
   - count_o stays 2, loc_top_o=0xB7; next pop -> 0xA0.
   - Same push+pop on an empty stack -> count_o=1, top=0xB7.
4. Start dump with 3 entries, toggling dump_ready_i low 2 cycles per beat.
   - dump_data_o is held stable while dump_ready_i=0; exactly 3 handshakes occur.
   - push/pop/clear issued during the dump have no effect; count_o=3 afterwards.
5. Assert rst asynchronously (between clock edges) mid-dump after 1 beat.
   - dump_valid_o=0, busy_o=0, count_o=0 immediately.
   - After release, dump_i yields no beats.
6. Same-cycle clear_i+push_i with count_o=2, overflow_o=1 -> count_o=0, overflow_o=0, push dropped.
